// File: rtl/rv_pkg.sv
// RV32I shared decode definitions: opcodes, immediate formats
// and the opcode classifiers used by ID and the branch-target logic.
package rv_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_fmt_e;

   function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
      imm_fmt_e f;
      f = IMM_NONE;
      unique case (1'b1)
         (op == OP_IMM || op == OP_LOAD || op == OP_JALR): f = IMM_I;
         (op == OP_STORE):                                 f = IMM_S;
         (op == OP_BRANCH):                                f = IMM_B;
         (op == OP_LUI || op == OP_AUIPC):                 f = IMM_U;
         (op == OP_JAL):                                   f = IMM_J;
         default:                                          f = IMM_NONE;
      endcase
      return f;
   endfunction

   function automatic logic is_known(input logic [6:0] op);
      return op == OP_LUI  || op == OP_AUIPC || op == OP_JAL
          || op == OP_JALR || op == OP_BRANCH || op == OP_LOAD
          || op == OP_STORE || op == OP_IMM  || op == OP_REG;
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// IF -> ID handshake: instruction, pc, valid and redirect in,
// stall back out to hold the fetch unit.
interface decode_stage_if #(
   parameter int XLEN = rv_pkg::XLEN_DEF
);
   logic            if_valid;
   logic [XLEN-1:0] if_pc;
   logic [31:0]     if_insn;
   logic            flush;
   logic            stall;

   modport master (
      output if_valid, if_pc, if_insn, flush,
      input  stall
   );

   modport slave (
      input  if_valid, if_pc, if_insn, flush,
      output stall
   );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate extractor, sign-extended to XLEN.
// Shared with the branch-target path.
module imm_gen
   import rv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [31:0]     insn,
   output logic [XLEN-1:0] imm
);

   logic signed [31:0] i32;

   always_comb begin
      i32 = '0;
      unique case (imm_fmt(insn[6:0]))
         IMM_I: i32 = {{20{insn[31]}}, insn[31:20]};
         IMM_S: i32 = {{20{insn[31]}}, insn[31:25], insn[11:7]};
         IMM_B: i32 = {{19{insn[31]}}, insn[31], insn[7],
                       insn[30:25], insn[11:8], 1'b0};
         IMM_U: i32 = {insn[31:12], 12'b0};
         IMM_J: i32 = {{11{insn[31]}}, insn[31], insn[19:12],
                       insn[20], insn[30:21], 1'b0};
         default: i32 = '0;
      endcase
      imm = XLEN'(i32);
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: decode, operand read with writeback bypass,
// load-use stall and the ID/EX pipeline register.
module decode_stage
   import rv_pkg::*;
#(
   parameter int XLEN      = XLEN_DEF,
   parameter int WB_BYPASS = 1
) (
   input  logic            clock,
   input  logic            reset_n,
   decode_stage_if.slave   fe,
   output logic [31:0]     addr_rs1,
   output logic [31:0]     addr_rs2,
   input  logic [XLEN-1:0] data_rs1,
   input  logic [XLEN-1:0] data_rs2,
   input  logic [31:0]     wb_addr_rd,
   input  logic [XLEN-1:0] wb_data_rd,
   input  logic            wb_write_enable,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1_val,
   output logic [XLEN-1:0] ex_rs2_val,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic [6:0]      ex_opcode,
   output logic [2:0]      ex_funct3,
   output logic [6:0]      ex_funct7,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic            ex_reg_write
);

   logic [6:0]      op;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [4:0]      rd;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic            bp1;
   logic            bp2;
   logic            uses_rs1;
   logic            uses_rs2;
   logic            writes_rd;
   logic            take;
   logic            hz;

   assign op  = fe.if_insn[6:0];
   assign rd  = fe.if_insn[11:7];
   assign rs1 = fe.if_insn[19:15];
   assign rs2 = fe.if_insn[24:20];

   assign addr_rs1 = {27'b0, rs1};
   assign addr_rs2 = {27'b0, rs2};

   imm_gen #(.XLEN(XLEN)) u_imm (
      .insn (fe.if_insn),
      .imm  (imm)
   );

   assign bp1 = (WB_BYPASS != 0) && wb_write_enable
             && (wb_addr_rd != 32'd0) && (wb_addr_rd == addr_rs1);
   assign bp2 = (WB_BYPASS != 0) && wb_write_enable
             && (wb_addr_rd != 32'd0) && (wb_addr_rd == addr_rs2);

   // x0 reads as zero whatever the file or writeback say
   assign rs1_val = (rs1 == 5'd0) ? '0 : (bp1 ? wb_data_rd : data_rs1);
   assign rs2_val = (rs2 == 5'd0) ? '0 : (bp2 ? wb_data_rd : data_rs2);

   assign uses_rs1 = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
   assign uses_rs2 = op == OP_REG || op == OP_STORE || op == OP_BRANCH;

   assign writes_rd = (rd != 5'd0)
                   && (op == OP_LUI  || op == OP_AUIPC || op == OP_JAL
                    || op == OP_JALR || op == OP_LOAD  || op == OP_IMM
                    || op == OP_REG);

   assign take = fe.if_valid && is_known(op);

   assign hz = fe.if_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0)
            && ((uses_rs1 && ex_rd == rs1) || (uses_rs2 && ex_rd == rs2));

   assign fe.stall = hz && !fe.flush;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ex_valid     <= 1'b0;
         ex_pc        <= '0;
         ex_rs1_val   <= '0;
         ex_rs2_val   <= '0;
         ex_imm       <= '0;
         ex_rs1       <= '0;
         ex_rs2       <= '0;
         ex_rd        <= '0;
         ex_opcode    <= '0;
         ex_funct3    <= '0;
         ex_funct7    <= '0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_reg_write <= 1'b0;
      end else if (fe.flush || hz) begin
         ex_valid     <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_reg_write <= 1'b0;
      end else begin
         ex_valid     <= take;
         ex_pc        <= fe.if_pc;
         ex_rs1_val   <= rs1_val;
         ex_rs2_val   <= rs2_val;
         ex_imm       <= imm;
         ex_rs1       <= rs1;
         ex_rs2       <= rs2;
         ex_rd        <= rd;
         ex_opcode    <= op;
         ex_funct3    <= fe.if_insn[14:12];
         ex_funct7    <= fe.if_insn[31:25];
         ex_mem_read  <= take && (op == OP_LOAD);
         ex_mem_write <= take && (op == OP_STORE);
         ex_reg_write <= take && writes_rd;
      end
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
ID stage of the five-stage RV32I pipeline.
- Takes the fetched instruction from IF and decodes it.
- Drives the register-file read addresses and captures the operand data, with writeback bypass.
- Detects load-use hazards and stalls IF.
- Registers everything into the ID/EX pipeline register consumed by execute.

Parameters:
XLEN, 32, datapath width for pc, operands and immediate.
WB_BYPASS, 1, 1 = forward same-cycle writeback data into operands; 0 = raw register-file data.

Ports:
clock  in  1  pipeline clock
reset_n  in  1  reset, synchronous, active-low
if_valid  in  1  if_insn/if_pc hold a real instruction
if_pc  in  XLEN  pc of if_insn
if_insn  in  32  instruction word
flush  in  1  branch/jump redirect from EX; kill ID contents
addr_rs1  out  32  register-file read address 1 (insn[19:15], zero-extended)
addr_rs2  out  32  register-file read address 2 (insn[24:20], zero-extended)
data_rs1  in  XLEN  register-file read data 1
data_rs2  in  XLEN  register-file read data 2
wb_addr_rd  in  32  writeback destination (also feeds the register file)
wb_data_rd  in  XLEN  writeback data
wb_write_enable  in  1  writeback valid
stall  out  1  hold IF (pc and IF/ID unchanged this cycle)
ex_valid  out  1  ID/EX holds a real instruction
ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  XLEN each  registered pc, operands, immediate
ex_rs1, ex_rs2, ex_rd  out  5 each  registered register indices
ex_opcode  out  7
ex_funct3  out  3
ex_funct7  out  7
ex_mem_read  out  1  instruction is a LOAD
ex_mem_write  out  1  instruction is a STORE
ex_reg_write  out  1  writes rd (forced 0 when rd==0)

Behaviour:
- Reset: on a rising clock with reset_n=0, every ex_* output is 0. Because stall derives from the ex_* registers, stall is 0 the cycle after reset. Reset mid-stall drops the bubble and the stall.
- Address outputs: addr_rs1/addr_rs2 are combinational from if_insn and are valid even when if_valid=0.
- Latency: exactly 1 cycle from IF/ID to ID/EX.
- Operand bypass (WB_BYPASS=1): operand = wb_data_rd when wb_write_enable, wb_addr_rd!=0 and wb_addr_rd==addr_rsN. Otherwise operand = data_rsN. Index 0 always yields 0 regardless of inputs.
- Register usage:
  - uses_rs1 = 0 for LUI, AUIPC, JAL; 1 otherwise.
  - uses_rs2 = 1 only for R-type, STORE and BRANCH.
- Immediate, sign-extended to XLEN:
  - I-type: OP-IMM, LOAD, JALR.
  - S-type: STORE.
  - B-type: BRANCH, bit0=0.
  - U-type: LUI, AUIPC, low 12 bits = 0.
  - J-type: JAL, bit0=0.
  - R-type: 0.
- Load-use hazard: hz = if_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((uses_rs1 & ex_rd==rs1) | (uses_rs2 & ex_rd==rs2)). This asserts for one cycle only, since the bubble clears ex_valid.
- stall = hz & ~flush. stall is combinational.
- Next-state priority, in order:
  1. reset_n=0 -> clear.
  2. flush -> ex_valid<=0, ex_mem_read/ex_mem_write/ex_reg_write<=0.
  3. hz -> bubble: same clears as flush.
  4. Otherwise, capture the decoded instruction with ex_valid<=if_valid.
- Unknown opcode: captured as a bubble (ex_valid=0, all control flags 0).
- A bubble never asserts ex_reg_write, ex_mem_read or ex_mem_write.
- Simultaneous flush and hz: flush wins and stall=0, so IF is free to redirect.
- Stall with writeback in the same cycle: the bypass applies this cycle. The register file holds the value on the retry cycle.

Decomposition:
- Shared package rv_pkg:
  - Opcode constants: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG.
  - Immediate-format enum: IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE.
  - XLEN default.
- One sub-module, imm_gen: purely combinational, insn -> imm. It is reused by the branch-target logic.

Test Plan:
- Reset: reset_n=0 for 2 cycles with if_valid=1 -> all ex_* outputs 0, stall=0; the first decode appears 1 cycle after release.
- Decode: addi x5,x1,-3 (0xFFD08293), data_rs1=0x10 -> next cycle ex_valid=1, ex_rd=5, ex_imm=0xFFFFFFFD, ex_rs1_val=0x10, ex_reg_write=1.
- Load-use: lw x6,0(x2) then add x7,x6,x3 -> during the add cycle stall=1, next ex_valid=0; the following cycle ex captures the add with ex_rs1=6.
- Bypass: add x8,x9,x9 with wb_write_enable=1, wb_addr_rd=9, wb_data_rd=0xABCD, data_rs1=data_rs2=0 -> ex_rs1_val=ex_rs2_val=0xABCD. Repeat with wb_addr_rd=0 -> operands 0.
- Flush over hazard: load-use condition plus flush=1 -> stall=0, next ex_valid=0, ex_mem_read=0.
- Immediates: beq x1,x2,-4 -> ex_imm=0xFFFFFFFC. jal x1,2048 -> ex_imm=0x00000800. lui x3,0x12345 -> ex_imm=0x12345000, uses_rs1=0, so no stall even if ex_rd matches.
